// File: rtl/icache_sa_nway.sv
// N-way set-associative read-only instruction cache with burst line refill,
// age-based LRU, critical-word capture, whole-cache invalidate and saturating counters.
module icache_sa_nway #(
  parameter int WAYS  = 4,
  parameter int SET_W = 8,
  parameter int OFF_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ok,
  output logic [31:0]      cpu_rdata,
  input  logic             inv,
  output logic             inv_busy,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic             mem_valid,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = 30 - SET_W - OFF_W;
  localparam int SETS  = 1 << SET_W;
  localparam int WORDS = 1 << OFF_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = SET_W + OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MREQ, S_REFILL, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        data_ram [WAYS][1 << IDX_W];
  logic [TAG_W-1:0]   tag_ram  [WAYS][SETS];
  logic [31:0]        rd_data_q [WAYS];
  logic [TAG_W-1:0]   rd_tag_q  [WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAY_W-1:0]   age_q   [SETS][WAYS];

  logic [TAG_W-1:0]   tag_q;
  logic [SET_W-1:0]   set_q;
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W-1:0]   beat_q;
  logic [WAY_W-1:0]   victim_q;
  logic [31:0]        crit_q;
  logic [31:0]        rdata_q;
  logic               inv_pend_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]   req_tag_s;
  logic [SET_W-1:0]   req_set_s;
  logic [OFF_W-1:0]   req_off_s;
  logic               accept_s, inv_exec_s, wr_beat_s, last_beat_s, lru_upd_s;
  logic               hit_any_s, found_s;
  logic [WAY_W-1:0]   hit_way_s, vic_s, acc_way_s, max_age_s;
  logic [31:0]        hit_word_s;
  logic               unused_s;

  assign req_tag_s   = cpu_addr[31:SET_W+OFF_W+2];
  assign req_set_s   = cpu_addr[SET_W+OFF_W+1:OFF_W+2];
  assign req_off_s   = cpu_addr[OFF_W+1:2];
  assign unused_s    = ^cpu_addr[1:0];

  assign accept_s    = (state_q == S_IDLE) && !inv_pend_q && cpu_req;
  assign inv_exec_s  = (state_q == S_IDLE) && inv_pend_q;
  assign wr_beat_s   = (state_q == S_REFILL) && mem_valid;
  assign last_beat_s = wr_beat_s && (beat_q == OFF_W'(WORDS - 1));
  assign lru_upd_s   = ((state_q == S_LOOKUP) && hit_any_s) || (state_q == S_DONE);
  assign acc_way_s   = (state_q == S_LOOKUP) ? hit_way_s : victim_q;

  assign mem_addr    = {tag_q, set_q, (OFF_W + 2)'(0)};
  assign inv_busy    = inv_pend_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

  // Per-way tag/data RAMs: refill writes, synchronous read of the requested set on accept.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (wr_beat_s && (victim_q == WAY_W'(w))) data_ram[w][{set_q, beat_q}] <= mem_rdata;
      if (last_beat_s && (victim_q == WAY_W'(w))) tag_ram[w][set_q] <= tag_q;
      if (accept_s) begin
        rd_data_q[w] <= data_ram[w][{req_set_s, req_off_s}];
        rd_tag_q[w]  <= tag_ram[w][req_set_s];
      end
    end
  end

  // Tag compare across all ways of the looked-up set.
  always_comb begin
    hit_any_s  = 1'b0;
    hit_way_s  = '0;
    hit_word_s = 32'h0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_q][w] && (rd_tag_q[w] == tag_q)) begin
        hit_any_s  = 1'b1;
        hit_way_s  = WAY_W'(w);
        hit_word_s = rd_data_q[w];
      end else begin
        hit_any_s  = hit_any_s;
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way (lowest index on a tie).
  always_comb begin
    vic_s     = '0;
    found_s   = 1'b0;
    max_age_s = age_q[set_q][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!found_s && !valid_q[set_q][w]) begin
        vic_s   = WAY_W'(w);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (!found_s) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[set_q][w] > max_age_s) begin
          max_age_s = age_q[set_q][w];
          vic_s     = WAY_W'(w);
        end else begin
          max_age_s = max_age_s;
        end
      end
    end else begin
      max_age_s = max_age_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_s) state_d = S_LOOKUP; else state_d = S_IDLE;
      S_LOOKUP: if (hit_any_s) state_d = S_IDLE; else state_d = S_MREQ;
      S_MREQ:   if (mem_ack) state_d = S_REFILL; else state_d = S_MREQ;
      S_REFILL: if (last_beat_s) state_d = S_DONE; else state_d = S_REFILL;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: lookup hits answer in the cycle after accept; refills answer from DONE.
  always_comb begin
    cpu_ok    = 1'b0;
    cpu_rdata = rdata_q;
    mem_req   = 1'b0;
    case (state_q)
      S_LOOKUP: begin
        if (hit_any_s) begin
          cpu_ok    = 1'b1;
          cpu_rdata = hit_word_s;
        end else begin
          cpu_ok    = 1'b0;
        end
      end
      S_MREQ:   mem_req = 1'b1;
      S_DONE: begin
        cpu_ok    = 1'b1;
        cpu_rdata = crit_q;
      end
      default:  cpu_ok = 1'b0;
    endcase
  end

  // Valid bits and LRU ages; invalidate restores the reset ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else if (inv_exec_s) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (last_beat_s) valid_q[set_q][victim_q] <= 1'b1;
      if (lru_upd_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[set_q][w] < age_q[set_q][acc_way_s])
            age_q[set_q][w] <= age_q[set_q][w] + WAY_W'(1);
        end
        age_q[set_q][acc_way_s] <= '0;
      end
    end
  end

  // Request latch, refill bookkeeping, read-data hold, counters and pending invalidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q      <= '0;
      set_q      <= '0;
      off_q      <= '0;
      beat_q     <= '0;
      victim_q   <= '0;
      crit_q     <= 32'h0;
      rdata_q    <= 32'h0;
      inv_pend_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept_s) begin
        tag_q <= req_tag_s;
        set_q <= req_set_s;
        off_q <= req_off_s;
      end
      if ((state_q == S_LOOKUP) && !hit_any_s) begin
        victim_q <= vic_s;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if ((state_q == S_LOOKUP) && hit_any_s && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if ((state_q == S_MREQ) && mem_ack) beat_q <= '0;
      else if (wr_beat_s) beat_q <= beat_q + OFF_W'(1);
      if (wr_beat_s && (beat_q == off_q)) crit_q <= mem_rdata;
      if (cpu_ok) rdata_q <= cpu_rdata;
      inv_pend_q <= (inv_pend_q && !inv_exec_s) || inv;
    end
  end

endmodule

// File: tb/tb_icache_sa_nway.sv
// Directed bench for icache_sa_nway: misses/refills, hit latency, LRU victim choice,
// invalidate during refill, counter saturation and reset in the middle of a refill.
module tb_icache_sa_nway;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req;
  logic [31:0]      cpu_addr;
  logic             cpu_ok;
  logic [31:0]      cpu_rdata;
  logic             inv;
  logic             inv_busy;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic             mem_valid;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int          checks = 0;
  int          errors = 0;
  int          exp_h  = 0;
  int          exp_m  = 0;
  logic [31:0] gen    = 32'h0;

  icache_sa_nway #(.WAYS(4), .SET_W(8), .OFF_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ok(cpu_ok),
    .cpu_rdata(cpu_rdata), .inv(inv), .inv_busy(inv_busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing memory: line 0x1000 returns 0xA000_0000 + word index; gen changes after reset.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2) - 32'h0000_0400 + gen;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One fetch with a reactive memory; inv_beat/rst_beat >= 0 inject events during refill.
  task automatic fetch(input string name, input logic [31:0] addr, input bit exp_miss,
                       input int inv_beat, input int rst_beat);
    logic [31:0] line;
    logic [31:0] rd;
    int cyc;
    int beat;
    bit acked;
    bit got;
    bit saw_req;
    bit aborted;
    line = addr & 32'hFFFF_FFC0;
    rd = 32'h0; cyc = 0; beat = 0;
    acked = 1'b0; got = 1'b0; saw_req = 1'b0; aborted = 1'b0;
    cpu_req = 1'b1;
    cpu_addr = addr;
    while (!got && !aborted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0; mem_valid = 1'b0; inv = 1'b0;
      if (cpu_ok) begin
        got = 1'b1;
        rd = cpu_rdata;
      end else if (mem_req && !acked) begin
        saw_req = 1'b1;
        acked = 1'b1;
        chk({name, ".mem_addr"}, mem_addr, line);
        mem_ack = 1'b1;
      end else if (acked && beat < 16) begin
        if (beat == rst_beat) begin
          rst = 1'b0;
          cpu_req = 1'b0;
          aborted = 1'b1;
        end else begin
          if (beat == inv_beat) inv = 1'b1;
          mem_valid = 1'b1;
          mem_rdata = mem_word(line + 32'(beat * 4));
          beat++;
        end
      end
    end
    if (aborted) begin
      #1;
      chk({name, ".rst_mem_req"}, 32'(mem_req), 32'h0);
      chk({name, ".rst_cpu_ok"}, 32'(cpu_ok), 32'h0);
      chk({name, ".rst_rdata"}, cpu_rdata, 32'h0);
      chk({name, ".rst_hit_cnt"}, 32'(hit_cnt), 32'h0);
      chk({name, ".rst_miss_cnt"}, 32'(miss_cnt), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_h = 0;
      exp_m = 0;
      @(negedge clk);
      return;
    end
    cpu_req = 1'b0;
    chk({name, ".ok"}, 32'(got), 32'h1);
    chk({name, ".rdata"}, rd, mem_word(addr));
    chk({name, ".miss"}, 32'(saw_req), 32'(exp_miss));
    chk({name, ".latency"}, 32'(cyc), exp_miss ? 32'd19 : 32'd1);
    if (exp_miss) chk({name, ".beats"}, 32'(beat), 32'd16);
    if (inv_beat >= 0) chk({name, ".inv_busy"}, 32'(inv_busy), 32'h1);
    if (exp_miss) begin
      if (exp_m < 15) exp_m++;
    end else begin
      if (exp_h < 15) exp_h++;
    end
    @(negedge clk);
    chk({name, ".hold_rdata"}, cpu_rdata, rd);
    chk({name, ".hit_cnt"}, 32'(hit_cnt), 32'(exp_h));
    chk({name, ".miss_cnt"}, 32'(miss_cnt), 32'(exp_m));
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; inv = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset.cpu_ok", 32'(cpu_ok), 32'h0);
    chk("reset.cpu_rdata", cpu_rdata, 32'h0);
    chk("reset.mem_req", 32'(mem_req), 32'h0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    chk("reset.inv_busy", 32'(inv_busy), 32'h0);
    chk("reset.hit_cnt", 32'(hit_cnt), 32'h0);
    chk("reset.miss_cnt", 32'(miss_cnt), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    fetch("first_miss", 32'h0000_1004, 1'b1, -1, -1);
    fetch("first_hit", 32'h0000_1008, 1'b0, -1, -1);

    // Set 0: tags 1..4 fill the ways, tag 1 becomes newest, tag 2 oldest.
    fetch("fill_t1", 32'h0000_4000, 1'b1, -1, -1);
    fetch("fill_t2", 32'h0000_8000, 1'b1, -1, -1);
    fetch("fill_t3", 32'h0000_C000, 1'b1, -1, -1);
    fetch("fill_t4", 32'h0001_0000, 1'b1, -1, -1);
    fetch("touch_t1", 32'h0000_4008, 1'b0, -1, -1);
    fetch("miss_t5", 32'h0001_4004, 1'b1, -1, -1);
    fetch("keep_t1", 32'h0000_400C, 1'b0, -1, -1);
    fetch("evicted_t2", 32'h0000_8010, 1'b1, -1, -1);

    // Invalidate while refilling; it completes the refill, then clears everything.
    fetch("inv_refill", 32'h0000_2000, 1'b1, 5, -1);
    chk("inv.busy_idle", 32'(inv_busy), 32'h1);
    @(negedge clk);
    chk("inv.busy_done", 32'(inv_busy), 32'h0);
    fetch("after_inv_1004", 32'h0000_1004, 1'b1, -1, -1);
    fetch("after_inv_2000", 32'h0000_2000, 1'b1, -1, -1);

    // 20 hits push the 4-bit hit counter into saturation.
    for (int i = 0; i < 20; i++) fetch("sat_hit", 32'h0000_1000 + 32'((i % 16) * 4), 1'b0, -1, -1);
    chk("sat.hit_cnt", 32'(hit_cnt), 32'h0000_000F);

    // Reset at beat 7; the line must be refetched in full with new data.
    fetch("rst_abort", 32'h0000_3010, 1'b1, -1, 7);
    gen = 32'h0100_0000;
    fetch("post_rst_miss", 32'h0000_3010, 1'b1, -1, -1);
    fetch("post_rst_hit", 32'h0000_3014, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_sa_nway.md
Name: icache_sa_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache with burst line refill.
- Sits between CPU fetch stage and the memory/bus bridge.
- Generalises the fixed 4-way/16-word Icache. Adds:
  - configurable way count, set count and line size
  - true age-based LRU held in flops
  - critical-word capture during refill
  - whole-cache invalidate
  - saturating hit/miss counters

Parameters:
WAYS, 4, associativity; power of two, 2..8
SET_W, 8, log2(number of sets)
OFF_W, 4, log2(words per line); line = 2^OFF_W 32-bit words
CNT_W, 32, width of hit/miss counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  fetch request; held with cpu_addr until cpu_ok
cpu_addr  in  32  byte address; bits [1:0] ignored
cpu_ok  out  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  out  32  fetched instruction word
inv  in  1  invalidate-all pulse
inv_busy  out  1  invalidate pending, not yet executed
mem_req  out  1  line read request, held until mem_ack
mem_addr  out  32  line-aligned address {tag,set,OFF_W+2 zeros}
mem_ack  in  1  request accepted
mem_valid  in  1  data beat valid
mem_rdata  in  32  beat data, ascending word order from offset 0
hit_cnt  out  CNT_W  saturating count of hits
miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Address split:
  - off = addr[OFF_W+1:2]
  - set = addr[SET_W+OFF_W+1:OFF_W+2]
  - tag = addr[31:SET_W+OFF_W+2], TAG_W = 30-SET_W-OFF_W
- Storage:
  - Data and tag: inferred synchronous-read RAM per way, not reset.
  - Valid bits and LRU ages: flops.
- Reset (rst low, async):
  - FSM to IDLE; all valids 0.
  - Ages of every set: age[w] = w.
  - Counters 0; inv pending 0.
  - Outputs: cpu_ok=0, cpu_rdata=0, mem_req=0, mem_addr=0, inv_busy=0.
- FSM states: IDLE, LOOKUP, MREQ, REFILL, DONE.
- IDLE:
  - If inv pending: clear all valids, reset ages, clear pending; cpu_req not accepted this cycle.
  - Else if cpu_req: latch address, issue RAM reads for that set, go to LOOKUP.
- LOOKUP:
  - hit[w] = valid[w][set] & (tag_ram[w] == tag). At most one hit by construction.
  - On hit: cpu_ok=1, cpu_rdata = word off of the hit way, LRU update, hit_cnt++, go to IDLE.
  - Hit latency: cpu_ok in the 2nd cycle counting the accept cycle as cycle 1.
  - On miss: choose victim (lowest-index invalid way; else max age, lowest index on tie). Latch victim, miss_cnt++, go to MREQ.
- MREQ:
  - mem_req=1, mem_addr line-aligned.
  - On mem_ack: beat counter = 0, go to REFILL. mem_req drops the cycle after ack.
- REFILL:
  - Each mem_valid writes mem_rdata to victim word[beat] and increments beat.
  - The beat with beat == off is captured as critical word.
  - Beat 2^OFF_W-1: write tag, set valid, go to DONE.
  - mem_valid outside REFILL is ignored.
  - Beat counter is OFF_W bits and wraps to 0 after the last beat.
- DONE: cpu_ok=1, cpu_rdata = critical word, LRU update on victim, go to IDLE.
- LRU update for accessed way a in set s:
  - Every way with age < age[a] increments; age[a] becomes 0.
  - Ages stay a permutation of 0..WAYS-1.
- inv:
  - A pulse in any state sets pending; inv_busy = pending.
  - Executed in the next IDLE cycle; an in-flight refill completes normally first.
  - inv while already pending has no extra effect.
- Counters: saturate at all-ones and hold.
- cpu_rdata: holds its last value between cpu_ok pulses.
- Reset mid-refill:
  - Immediate return to IDLE, mem_req=0.
  - The partially written line stays invalid.
  - The memory side must discard the outstanding burst.
- cpu_req dropping before cpu_ok is illegal; behaviour is undefined.

Test Plan:
- Reset, then fetch 0x0000_1004 -> miss: mem_req with mem_addr=0x0000_1000. Return 16 beats of data 0xA000_0000+i -> cpu_ok with cpu_rdata=0xA000_0001; miss_cnt=1.
- Re-fetch 0x0000_1008 -> cpu_ok 1 cycle after accept, rdata=0xA000_0002, no mem_req, hit_cnt=1.
- Fill set 0 with tags 1..4 (WAYS=4), touch tag 1, then miss on tag 5 -> tag 2's way evicted. Refetch tag 1 -> hit; tag 2 -> miss.
- Pulse inv during REFILL -> inv_busy=1 until the refill completes and the FSM reaches IDLE. Next fetch of any previously cached line -> miss.
- CNT_W=4: 20 hits -> hit_cnt stays 4'hF.
- Drive rst low at beat 7 of a refill, release, fetch the same address -> miss with a full new refill. cpu_ok only after 16 new beats.
